// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and helpers for the bit-serial subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fullsub_bit.sv
// rtl/fullsub_bit.sv - one-bit full subtractor built from two half subtractors
module fullsub_bit (
  input  logic a,
  input  logic bb,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  halfsub u_hs_ab (
    .a    (a),
    .bb   (bb),
    .diff (d1),
    .bout (b1)
  );

  halfsub u_hs_bin (
    .a    (d1),
    .bb   (bin),
    .diff (diff),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/halfsub.sv
// rtl/halfsub.sv - one-bit half subtractor
module halfsub (
  input  logic a,
  input  logic bb,
  output logic diff,
  output logic bout
);

  assign diff = a ^ bb;
  assign bout = ~a & bb;

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial A-B controller, one slice, LSB first, WIDTH+1 cycle latency
// SERIAL_SUB_FLAGS_EN adds registered zero/neg result flags.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             b,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic             slice_diff;
  logic             slice_bout;

  fullsub_bit u_slice (
    .a    (a_sr_q[0]),
    .bb   (b_sr_q[0]),
    .bin  (borrow_q),
    .diff (slice_diff),
    .bout (slice_bout)
  );

  // Each new difference bit enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
  assign d_d = (d_q >> 1) | (WIDTH'(slice_diff) << (WIDTH - 1));

`ifdef SERIAL_SUB_FLAGS_EN
  logic zero_q;
  logic neg_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q   <= A;
            b_sr_q   <= B;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          d_q      <= d_d;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          borrow_q <= slice_bout;
          if (cnt_q == LAST) begin
            bout_q  <= slice_bout;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_q  <= (d_q == '0);
          neg_q   <= bout_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign D    = d_q;
  assign b    = bout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero = zero_q;
  assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed vector bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1)
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [7:0] D;
  logic       b;
  logic       busy;
  logic       done;

  logic       start1 = 1'b0;
  logic [0:0] A1 = '0;
  logic [0:0] B1 = '0;
  logic [0:0] D1;
  logic       b1;
  logic       busy1;
  logic       done1;

`ifdef SERIAL_SUB_FLAGS_EN
  logic zero, neg, zero1, neg1;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .D     (D),
    .b     (b),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero  (zero),
    .neg   (neg)
`endif
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .A     (A1),
    .B     (B1),
    .D     (D1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero  (zero1),
    .neg   (neg1)
`endif
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] bv;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation on the WIDTH=8 instance and watch W+2 cycles after the start edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] bv, input logic [7:0] exp_d,
                        input logic exp_b, input bit hold, input string tag);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    int overlap  = 0;
    start = 1'b1;
    A = a;
    B = bv;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (hold && i == 3) begin
        A = 8'hFF;
        B = 8'hFF;
      end
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    start = 1'b0;
    chk({tag, " busy_cycles"}, busy_cnt, 8);
    chk({tag, " done_latency"}, done_at, 9);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " busy_done_overlap"}, overlap, 0);
    chk({tag, " D"}, D, exp_d);
    chk({tag, " b"}, b, exp_b);
`ifdef SERIAL_SUB_FLAGS_EN
    chk({tag, " zero"}, zero, (exp_d == 8'h00));
    chk({tag, " neg"}, neg, exp_b);
`endif
  endtask

  task automatic run1(input logic a, input logic bv, input logic exp_d, input logic exp_b,
                      input string tag);
    int busy_cnt = 0;
    int done_at  = -1;
    start1 = 1'b1;
    A1 = a;
    B1 = bv;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (busy1) busy_cnt++;
      if (done1 && done_at < 0) done_at = i;
    end
    chk({tag, " busy_cycles"}, busy_cnt, 1);
    chk({tag, " done_latency"}, done_at, 2);
    chk({tag, " D"}, D1, exp_d);
    chk({tag, " b"}, b1, exp_b);
  endtask

  initial begin
    vecs[0] = '{a: 8'h05, bv: 8'h03, d: 8'h02, bo: 1'b0};
    vecs[1] = '{a: 8'h03, bv: 8'h05, d: 8'hFE, bo: 1'b1};
    vecs[2] = '{a: 8'h00, bv: 8'h00, d: 8'h00, bo: 1'b0};
    vecs[3] = '{a: 8'hFF, bv: 8'hFF, d: 8'h00, bo: 1'b0};
    vecs[4] = '{a: 8'h80, bv: 8'h01, d: 8'h7F, bo: 1'b0};
    vecs[5] = '{a: 8'h00, bv: 8'h01, d: 8'hFF, bo: 1'b1};
    vecs[6] = '{a: 8'h12, bv: 8'h34, d: 8'hDE, bo: 1'b1};
    vecs[7] = '{a: 8'hFF, bv: 8'h00, d: 8'hFF, bo: 1'b0};

    repeat (2) @(negedge clk);
    chk("reset D", D, 8'h00);
    chk("reset b", b, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each start is driven in the cycle right after the previous done.
    for (int v = 0; v < 8; v++)
      run_op(vecs[v].a, vecs[v].bv, vecs[v].d, vecs[v].bo, 1'b0, $sformatf("vec%0d", v));

    run_op(8'hA0, 8'h0F, 8'h91, 1'b0, 1'b1, "held_start");
    @(negedge clk);
    chk("held_start no_restart", busy, 1'b0);

    begin : reset_mid_run
      int done_seen = 0;
      start = 1'b1;
      A = 8'h10;
      B = 8'h01;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst D", D, 8'h00);
      chk("midrst b", b, 1'b0);
      chk("midrst busy", busy, 1'b0);
      chk("midrst done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done || busy) done_seen++;
      end
      chk("midrst no_done", done_seen, 0);
    end
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "after_rst");

    run1(1'b0, 1'b1, 1'b1, 1'b1, "w1_0m1");
    run1(1'b1, 1'b1, 1'b0, 1'b0, "w1_1m1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial N-bit subtractor controller that computes D = A − B over WIDTH clock cycles using a single 1-bit subtractor slice. The slice is built from two half subtractors. The controller latches the operands on a start request, shifts them LSB-first through the slice, and carries the borrow between cycles in a flop. It presents the difference and the final borrow with a done pulse. It sits where a multi-bit subtract is needed but area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk edge, honoured only in IDLE
- A  input  WIDTH  minuend; sampled together with an honoured start
- B  input  WIDTH  subtrahend; sampled together with an honoured start
- D  output  WIDTH  difference A − B modulo 2^WIDTH
- b  output  1  final borrow out; 1 when A < B (unsigned)
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; D and b are valid from this cycle

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE → RUN on start=1. This loads the A/B shift registers, clears the borrow flop and clears the bit counter.
  - RUN → RUN while counter < WIDTH−1. Each cycle:
    - the slice computes diff = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
    - diff is shifted into the D shift register from the MSB side, and the A/B registers shift right;
    - the borrow flop takes bout, and the counter increments.
  - RUN → DONE after the cycle with counter = WIDTH−1. In that cycle, b takes the final bout.
  - DONE → IDLE unconditionally after one cycle.
- start in RUN or DONE is ignored; operands are not resampled.
- A/B changes after the start edge have no effect on the result in flight.
- D and b hold their last result from DONE until the next honoured start. During RUN, D holds a partially shifted value and must not be consumed.
- Counter width is max(1, $clog2(WIDTH)). The counter never wraps: the DONE transition happens at WIDTH−1.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state=IDLE, D=0, b=0, busy=0, done=0, counter=0, borrow flop=0, zero/neg=0.
- Reset asserted mid-RUN aborts the operation. There is no done pulse, and the block returns to IDLE after rst_n deasserts.
- Start honoured at edge k:
  - busy=1 from edge k through edge k+WIDTH;
  - done=1 for one cycle after edge k+WIDTH+1;
  - D and b are final from edge k+WIDTH+1.
- Latency from start edge to done is WIDTH+1 cycles.
- The earliest next honoured start is at edge k+WIDTH+2, which is the cycle after done. Throughput is one result per WIDTH+2 cycles.
- busy and done are never high simultaneously.

## Configuration
- SERIAL_SUB_FLAGS_EN defined: adds two outputs, zero (1 bit) and neg (1 bit).
  - zero = (D == 0) and neg = b, both registered at the DONE transition.
  - Both hold with D, and both reset to 0.
- SERIAL_SUB_FLAGS_EN not defined: the zero and neg ports and their logic are absent. All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds:
  - the state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a localparam function for the counter width.
- One sub-module, fullsub_bit. It is combinational and built from two existing halfsub instances plus an OR of their borrows.
  - Ports: a, bb, bin, diff, bout.
  - It is instantiated once in serial_sub_ctrl.

## Test plan
- WIDTH=8, A=8'h05, B=8'h03, start pulse → busy 8 cycles, done 9 cycles after the start edge, D=8'h02, b=0, zero=0.
- A=8'h03, B=8'h05 → D=8'hFE, b=1, neg=1.
- A=8'h00, B=8'h00, then A=8'hFF, B=8'hFF → D=8'h00, b=0, zero=1 both times. Back-to-back starts are issued the cycle after each done.
- A=8'hA0, B=8'h0F with start held high for the whole run, and A/B changed mid-run → exactly one done, D=8'h91, no restart until IDLE.
- rst_n pulsed low at RUN cycle 4 of A=8'h10, B=8'h01 → all outputs 0 immediately, no done. A new start then gives D=8'h0F, b=0.
- WIDTH=1: A=0, B=1 → done 2 cycles after start, D=1, b=1. A=1, B=1 → D=0, b=0.
